uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter with a one-entry holding register in front of the
// shift register, so a producer can queue the next byte while the current
// frame is still on the line and frames follow each other with no idle gap.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD_RATE  line bit rate; each bit lasts CLK_FREQ/BAUD_RATE clocks
//
// Ports
//   clk       system clock, all state updates on the rising edge
//   rst_n     asynchronous active-low reset (aborts any frame, drops buffer)
//   tx_data   byte to send, sampled only on an accepted handshake
//   tx_valid  producer offers tx_data this cycle
//   tx_ready  holding register is empty (registered)
//   tx        serial line, idle high, driven straight from a flop
//   busy      a start, data or stop bit is on the line
//   tx_done   one-cycle pulse in the last clock of each stop bit
//
// Handshake: a byte transfers on every rising edge where tx_valid && tx_ready.
// tx_ready depends only on the holding-register flag, never on tx_valid, and
// the producer may hold tx_valid high across several transfers.
// -----------------------------------------------------------------------------
module uart_tx #(
  parameter int CLK_FREQ  = 12000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_BITS     = $clog2(CLKS_PER_BIT);
  localparam int CNT_W        = (CNT_BITS > 16) ? CNT_BITS : 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_cnt_next;
  logic [2:0]       bit_idx;
  logic [2:0]       bit_idx_next;
  logic [7:0]       shift;
  logic [7:0]       shift_next;
  logic [7:0]       hold_data;
  logic             hold_full;
  logic             tx_q;
  logic             tx_next;

  logic             bit_end;
  logic             accept;
  logic             load;

  // Last clock of the current bit period.
  assign bit_end = (baud_cnt == LAST_CNT);

  // Accept and load are mutually exclusive: accept needs an empty holding
  // register, load needs a full one. A byte accepted on the same edge that
  // the register drains is therefore impossible, so nothing is overwritten.
  assign accept = tx_valid && !hold_full;
  assign load   = hold_full && ((state == IDLE) || ((state == STOP) && bit_end));

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_cnt_next;
      bit_idx  <= bit_idx_next;
      shift    <= shift_next;
      tx_q     <= tx_next;
      if (accept) begin
        hold_data <= tx_data;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state;
    bit_idx_next  = bit_idx;
    shift_next    = shift;
    // Every transition happens on bit_end (or out of IDLE, where the counter
    // is already held at zero), so this also clears the counter on each
    // state entry and at each data-bit boundary.
    baud_cnt_next = ((state == IDLE) || bit_end) ? '0 : baud_cnt + 1'b1;

    if (load) begin
      shift_next = hold_data;
    end

    case (state)
      IDLE: begin
        if (hold_full) begin
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next   = DATA;
          bit_idx_next = 3'd0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next   = {1'b0, shift[7:1]};
          bit_idx_next = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_next = hold_full ? START : IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    // The line level is computed from the state being entered so the tx flop
    // changes on the same edge as the state register; a byte loaded in IDLE
    // therefore shows its start bit right after the load edge.
    tx_next = 1'b1;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase

    tx       = tx_q;
    tx_ready = !hold_full;
    busy     = (state != IDLE);
    tx_done  = (state == STOP) && bit_end;
  end

endmodule
